// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXDATA/STATUS/RXDATA/CTRL registers on the core data bus,
// one-byte receive holding register with overrun and framing-error flags.
module uart_mmio #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] data_address,
  input  logic [31:0] writedata,
  output logic        hit,
  output logic [31:0] read_data,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_s1, rx_s2;

  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, rx_frame_err;

  logic [3:0] off;
  logic       tx_wr, ctrl_wr, rx_rd, tx_busy, rx_done, rx_bad;
  logic       unused_wdata;

  assign off          = data_address[3:0];
  assign hit          = (data_address[31:4] == BASE_ADDR[31:4]);
  assign tx_wr        = memwrite & hit & (off == 4'h0);
  assign ctrl_wr      = memwrite & hit & (off == 4'hC);
  assign rx_rd        = memread & hit & (off == 4'h8);
  assign tx_busy      = (tx_state != TX_IDLE);
  assign unused_wdata = ^writedata[31:8];

  always_comb begin
    read_data = '0;
    if (hit) begin
      case (off)
        4'h4:    read_data = {28'd0, rx_frame_err, rx_overrun, rx_valid, tx_busy};
        4'h8:    read_data = {24'd0, rx_data};
        default: read_data = '0;
      endcase
    end
  end

  // A write landing on the final stop-bit cycle starts the next frame with no idle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_wr) begin
          tx_shift <= writedata[7:0];
          tx_cnt   <= '0;
          uart_tx  <= 1'b0;
          tx_state <= TX_START;
        end
        TX_START: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_idx   <= '0;
          uart_tx  <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_state <= TX_DATA;
        end else tx_cnt <= tx_cnt + CW'(1);
        TX_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_idx == 3'd7) begin
            uart_tx  <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= tx_idx + 3'd1;
          end
        end else tx_cnt <= tx_cnt + CW'(1);
        TX_STOP: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_wr) begin
            tx_shift <= writedata[7:0];
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end else tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + CW'(1);
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s2) rx_state <= RX_START;
        end
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_idx   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + CW'(1);
        RX_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_idx   <= rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + CW'(1);
        RX_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
        end else rx_cnt <= rx_cnt + CW'(1);
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_done = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s2;
  assign rx_bad  = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && !rx_s2;

  // Clears are written first so a same-cycle error event overrides them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (ctrl_wr && writedata[0]) rx_overrun   <= 1'b0;
      if (ctrl_wr && writedata[1]) rx_frame_err <= 1'b0;
      if (rx_bad) rx_frame_err <= 1'b1;
      if (rx_done) begin
        if (!rx_valid || rx_rd) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else rx_overrun <= 1'b1;
      end else if (rx_rd) rx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Randomised scoreboard bench for uart_mmio: bus reads and serial TX frames are checked
// by independent monitors against a register-level model kept in the bench.
module tb_uart_mmio;
  localparam int N = 4;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0, reset = 1'b1, memread = 1'b0, memwrite = 1'b0;
  logic [31:0] data_address = '0, writedata = '0;
  logic        hit, uart_rx, uart_tx;
  logic [31:0] read_data;
  logic        rx_drv = 1'b1;

  // TX is looped back; the bench can also pull the line low to inject frames.
  assign uart_rx = uart_tx & rx_drv;

  uart_mmio #(.CLKS_PER_BIT(N), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .data_address(data_address), .writedata(writedata), .hit(hit),
    .read_data(read_data), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [31:0] rd_q[$];
  string       rd_name[$];
  logic [7:0]  tx_q[$];

  logic       m_valid = 0, m_ovr = 0, m_ferr = 0;
  logic [7:0] m_data = 0;
  int         tx_end = 0;

  function automatic logic [31:0] exp_status();
    return {28'd0, m_ferr, m_ovr, m_valid, logic'(cyc < tx_end)};
  endfunction

  function automatic void model_deliver(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (!m_valid) begin m_data = b; m_valid = 1'b1; end
    else m_ovr = 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    data_address = addr; memread = 1'b1;
    rd_q.push_back(exp); rd_name.push_back(nm);
    tick(1);
    memread = 1'b0;
  endtask

  task automatic rd_status(input string nm);
    rd(BASE + 32'h4, exp_status(), nm);
  endtask

  task automatic rd_rxdata(input string nm);
    rd(BASE + 32'h8, {24'd0, m_data}, nm);
    m_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    data_address = addr; writedata = data; memwrite = 1'b1;
    if (addr == BASE && cyc + 1 >= tx_end) begin
      tx_q.push_back(data[7:0]);
      tx_end = cyc + 1 + 10 * N;
    end
    if (addr == BASE + 32'hC) begin
      if (data[0]) m_ovr = 1'b0;
      if (data[1]) m_ferr = 1'b0;
    end
    tick(1);
    memwrite = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin rx_drv = bits[i]; tick(N); end
    rx_drv = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_data = 0; tx_end = 0;
  endtask

  // Read monitor
  always @(negedge clk) begin
    if (memread) begin
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: read_data=%h with no expectation", read_data);
      end else begin
        logic [31:0] e;
        string nm;
        e = rd_q.pop_front();
        nm = rd_name.pop_front();
        chk(nm, read_data, e);
      end
    end
  end

  // TX frame monitor: every cycle of every bit period must hold the expected level.
  initial begin
    logic       prev;
    logic [9:0] bits, obs;
    logic [7:0] e;
    int         bad;
    bit         abort;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && prev && !uart_tx) begin
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected_frame: start bit seen at cycle %0d, none expected", cyc);
        end else begin
          e = tx_q.pop_front();
          bits = {1'b1, e, 1'b0};
          obs = '0; bad = 0; abort = 0;
          for (int i = 0; i < 10 && !abort; i++) begin
            for (int j = (i == 0) ? 1 : 0; j < N && !abort; j++) begin
              @(negedge clk);
              if (reset) abort = 1;
              else begin
                obs[i] = uart_tx;
                if (uart_tx !== bits[i]) bad++;
              end
            end
          end
          if (!abort) begin
            checks++;
            if (bad != 0) begin
              errors++;
              $display("FAIL tx_frame: got bits %b expected %b (%0d bad samples)", obs, bits, bad);
            end
          end
        end
      end
      prev = uart_tx;
    end
  end

  initial begin
    int k;
    logic [7:0] b, b2;
    logic stop;
    tick(3);
    reset = 1'b0;

    // reset state
    chk("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    data_address = BASE + 32'h4; #1;
    chk("hit_base", {31'd0, hit}, 32'd1);
    data_address = BASE + 32'h10; #1;
    chk("hit_miss", {31'd0, hit}, 32'd0);
    rd_status("reset_status");
    rd_rxdata("reset_rxdata");
    rd(BASE + 32'hC, 32'd0, "reset_ctrl");
    rd(BASE + 32'h0, 32'd0, "reset_txdata");

    // 0xA5 frame, ignored write while busy, busy-fall timing, loopback receive
    wr(BASE, 32'h0000_00A5);
    k = cyc;
    wr(BASE, 32'h0000_003C);
    while (cyc < k + 39) tick(1);
    rd_status("busy_at_k39");
    rd_status("idle_at_k40");
    tick(12);
    model_deliver(8'hA5, 1'b1);
    rd_status("status_after_a5");
    rd_rxdata("rxdata_a5");
    rd_status("status_after_rxread");

    // overrun, then CTRL clear
    send_rx(8'h11, 1'b1); tick(12); model_deliver(8'h11, 1'b1);
    send_rx(8'h22, 1'b1); tick(12); model_deliver(8'h22, 1'b1);
    rd_status("status_overrun");
    wr(BASE + 32'hC, 32'h1);
    rd_status("status_ovr_cleared");
    rd_rxdata("rxdata_kept_old");

    // glitch, then bad stop bit
    rx_drv = 1'b0; tick(1); rx_drv = 1'b1;
    tick(3 * N);
    rd_status("status_after_glitch");
    send_rx(8'h5A, 1'b0); tick(12); model_deliver(8'h5A, 1'b0);
    rd_status("status_frame_err");
    rd_rxdata("rxdata_after_ferr");
    wr(BASE + 32'hC, 32'h2);
    rd_status("status_ferr_cleared");

    // reset mid-frame
    wr(BASE, {24'd0, 8'($urandom)});
    k = cyc;
    while (cyc < k + 14) tick(1);
    reset = 1'b1; tick(1); reset = 1'b0;
    model_reset();
    chk("midframe_reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    rd_status("midframe_reset_status");
    wr(BASE, 32'h96); tick(10 * N + 12); model_deliver(8'h96, 1'b1);
    rd_rxdata("rxdata_after_reset_frame");

    // randomised traffic
    for (int it = 0; it < 12; it++) begin
      b = 8'($urandom); b2 = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin wr(BASE, {24'd0, b}); tick(10 * N + 12); model_deliver(b, 1'b1); end
        1: begin
          wr(BASE, {24'd0, b});
          while (cyc + 1 < tx_end) tick(1);
          wr(BASE, {24'd0, b2});
          tick(10 * N + 12);
          model_deliver(b, 1'b1); model_deliver(b2, 1'b1);
        end
        2: begin
          stop = ($urandom_range(0, 3) != 0);
          send_rx(b, stop); tick(12); model_deliver(b, stop);
        end
        default: wr(BASE + 32'hC, 32'($urandom_range(0, 3)));
      endcase
      rd_status("rand_status");
      if ($urandom_range(0, 1) == 1) rd_rxdata("rand_rxdata");
    end

    for (int t = 0; t < 2000 && (tx_q.size() != 0 || rd_q.size() != 0); t++) tick(1);
    chk("tx_queue_drained", tx_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
